// File: rtl/monitor_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : monitor_scoreboard
//  Purpose  : Scoreboard for the reduction check path. It samples the stimulus
//             word in1 and recomputes the expected result (|in1) & (&in1). The
//             expected value is aligned with dut_out through a LATENCY-deep
//             delay line, and each valid sample is compared while in RUN.
//             The block keeps saturating pass/error counters, a sticky fail
//             flag and an optional first-failure capture.
//  Ports    : CLK          clock, all state on posedge
//             RESET        synchronous, active-high
//             start        begin/restart a checking run (from IDLE or DONE)
//             stop         end the run (RUN -> DONE)
//             in_valid     in1 carries a sample this cycle
//             in1          [WIDTH] stimulus word driven to the DUT
//             dut_out      DUT result, LATENCY cycles after its sample
//             state        [2] 00 IDLE, 01 RUN, 10 HALT, 11 DONE
//             check_count  [CNT_W] comparisons performed (saturating)
//             err_count    [CNT_W] mismatches seen (saturating)
//             mismatch     one-cycle pulse per mismatch
//             fail         sticky mismatch flag, cleared by an accepted start
//             fail_data    [WIDTH] in1 of the first mismatching sample
//             fail_cycle   [CNT_W] check_count at the first mismatch
//  Config   : MONITOR_SCOREBOARD_CAPTURE_EN - when defined, fail_data and
//             fail_cycle are registered captures; otherwise they are tied to 0.
//  Revision : 1.0  initial release
// ============================================================================
module monitor_scoreboard #(
  parameter int WIDTH        = 4,
  parameter int LATENCY      = 1,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic             dut_out,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic             mismatch,
  output logic             fail,
  output logic [WIDTH-1:0] fail_data,
  output logic [CNT_W-1:0] fail_cycle
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10,
    S_DONE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t cur_state;
  logic   run;
  logic   start_accept;
  logic   samp_exp;
  logic   d_valid;
  logic   [WIDTH-1:0] d_data;
  logic   d_exp;
  logic   cmp;
  logic   mis;

  assign state        = cur_state;
  assign run          = (cur_state == S_RUN);
  assign start_accept = start && ((cur_state == S_IDLE) || (cur_state == S_DONE));
  assign samp_exp     = (|in1) & (&in1);

  // Delay line carrying {valid, in1, expected}. Valid bits are cleared on
  // every edge taken outside RUN, which both drops samples left in flight
  // when a run ends and flushes the line before a restarted run.
  generate
    if (LATENCY == 0) begin : g_lat0
      assign d_valid = in_valid;
      assign d_data  = in1;
      assign d_exp   = samp_exp;
    end else begin : g_pipe
      logic [LATENCY-1:0]            v_q;
      logic [LATENCY-1:0]            exp_q;
      logic [LATENCY-1:0][WIDTH-1:0] data_q;

      always_ff @(posedge CLK) begin
        if (RESET || !run) begin
          v_q <= '0;
        end else begin
          v_q[0] <= in_valid;
          for (int k = 1; k < LATENCY; k++) begin
            v_q[k] <= v_q[k-1];
          end
        end
        data_q[0] <= in1;
        exp_q[0]  <= samp_exp;
        for (int k = 1; k < LATENCY; k++) begin
          data_q[k] <= data_q[k-1];
          exp_q[k]  <= exp_q[k-1];
        end
      end

      assign d_valid = v_q[LATENCY-1];
      assign d_data  = data_q[LATENCY-1];
      assign d_exp   = exp_q[LATENCY-1];
    end
  endgenerate

  // Case inequality so that an X/Z on dut_out is reported as a mismatch.
  assign cmp = run && d_valid;
  assign mis = cmp && (dut_out !== d_exp);

  // FSM, counters, mismatch pulse and sticky fail.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cur_state   <= S_IDLE;
      check_count <= '0;
      err_count   <= '0;
      mismatch    <= 1'b0;
      fail        <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (cur_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cur_state   <= S_RUN;
            check_count <= '0;
            err_count   <= '0;
            fail        <= 1'b0;
          end
        end
        S_RUN: begin
          if (cmp && (check_count != CNT_MAX)) begin
            check_count <= check_count + 1'b1;
          end
          if (mis) begin
            mismatch <= 1'b1;
            fail     <= 1'b1;
            if (err_count != CNT_MAX) begin
              err_count <= err_count + 1'b1;
            end
          end
          // stop wins over halting: a coincident mismatch is still counted.
          if (stop) begin
            cur_state <= S_DONE;
          end else if (mis && (STOP_ON_FAIL != 0)) begin
            cur_state <= S_HALT;
          end
        end
        default: begin
          // HALT: everything frozen until RESET.
        end
      endcase
    end
  end

`ifdef MONITOR_SCOREBOARD_CAPTURE_EN
  // First-failure capture; fail is still 0 on the cycle of the first mismatch.
  always_ff @(posedge CLK) begin
    if (RESET || start_accept) begin
      fail_data  <= '0;
      fail_cycle <= '0;
    end else if (mis && !fail) begin
      fail_data  <= d_data;
      fail_cycle <= check_count;
    end
  end
`else
  assign fail_data  = '0;
  assign fail_cycle = '0;

  // The delayed data word only feeds the capture registers.
  logic unused_capture;
  assign unused_capture = ^{d_data, start_accept};
`endif

endmodule
`default_nettype wire

// File: tb/tb_monitor_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_monitor_scoreboard
//  Purpose  : Self-checking bench for monitor_scoreboard. Three instances share
//             one stimulus stream: default parameters, STOP_ON_FAIL=1 and
//             CNT_W=4. A per-instance reference model, built from the run /
//             halt / done rules and a cycle-tagged sample table, predicts
//             every output after each clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_monitor_scoreboard;

  localparam int W   = 4;
  localparam int LAT = 1;
  localparam int ALL = (1 << W) - 1;

`ifdef MONITOR_SCOREBOARD_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  localparam int ST_IDLE = 0;
  localparam int ST_RUN  = 1;
  localparam int ST_HALT = 2;
  localparam int ST_DONE = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         stop;
  logic         in_valid;
  logic [W-1:0] in1;
  logic         dut_out;

  logic [1:0]   a_state, b_state, c_state;
  logic [15:0]  a_cc, a_ec, a_fc, b_cc, b_ec, b_fc;
  logic [3:0]   c_cc, c_ec, c_fc;
  logic         a_mis, a_fail, b_mis, b_fail, c_mis, c_fail;
  logic [W-1:0] a_fd, b_fd, c_fd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  monitor_scoreboard #(.WIDTH(W), .LATENCY(LAT), .CNT_W(16), .STOP_ON_FAIL(0)) u_main (
    .CLK(clk), .RESET(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in1(in1), .dut_out(dut_out), .state(a_state), .check_count(a_cc),
    .err_count(a_ec), .mismatch(a_mis), .fail(a_fail), .fail_data(a_fd),
    .fail_cycle(a_fc));

  monitor_scoreboard #(.WIDTH(W), .LATENCY(LAT), .CNT_W(16), .STOP_ON_FAIL(1)) u_halt (
    .CLK(clk), .RESET(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in1(in1), .dut_out(dut_out), .state(b_state), .check_count(b_cc),
    .err_count(b_ec), .mismatch(b_mis), .fail(b_fail), .fail_data(b_fd),
    .fail_cycle(b_fc));

  monitor_scoreboard #(.WIDTH(W), .LATENCY(LAT), .CNT_W(4), .STOP_ON_FAIL(0)) u_sat (
    .CLK(clk), .RESET(rst), .start(start), .stop(stop), .in_valid(in_valid),
    .in1(in1), .dut_out(dut_out), .state(c_state), .check_count(c_cc),
    .err_count(c_ec), .mismatch(c_mis), .fail(c_fail), .fail_data(c_fd),
    .fail_cycle(c_fc));

  // ---------------- reference model ----------------
  int m_max [3] = '{65535, 65535, 15};
  bit m_sof [3] = '{1'b0, 1'b1, 1'b0};
  int m_st  [3];
  int m_cc  [3];
  int m_ec  [3];
  int m_mis [3];
  int m_fail[3];
  int m_fd  [3];
  int m_fc  [3];
  int s_cyc [3][16];   // cycle at which the entry was sampled, -1 = none
  int s_dat [3][16];
  int cyc = 0;

  task automatic flush(input int i);
    for (int k = 0; k < 16; k++) s_cyc[i][k] = -1;
  endtask

  task automatic model_tick();
    for (int i = 0; i < 3; i++) begin
      bit m;
      int pc;
      m = 1'b0;
      m_mis[i] = 0;
      if (rst) begin
        m_st[i] = ST_IDLE; m_cc[i] = 0; m_ec[i] = 0; m_fail[i] = 0;
        m_fd[i] = 0; m_fc[i] = 0;
        flush(i);
      end else begin
        case (m_st[i])
          ST_IDLE, ST_DONE: begin
            if (start) begin
              m_st[i] = ST_RUN; m_cc[i] = 0; m_ec[i] = 0; m_fail[i] = 0;
              m_fd[i] = 0; m_fc[i] = 0;
              flush(i);
            end
          end
          ST_RUN: begin
            pc = cyc - LAT;
            if (pc >= 0 && s_cyc[i][pc % 16] == pc) begin
              m = (int'(dut_out) != ((s_dat[i][pc % 16] == ALL) ? 1 : 0));
              if (m) begin
                m_mis[i] = 1;
                if (m_fail[i] == 0) begin
                  m_fail[i] = 1; m_fd[i] = s_dat[i][pc % 16]; m_fc[i] = m_cc[i];
                end
                if (m_ec[i] < m_max[i]) m_ec[i]++;
              end
              if (m_cc[i] < m_max[i]) m_cc[i]++;
            end
            if (in_valid) begin
              s_cyc[i][cyc % 16] = cyc;
              s_dat[i][cyc % 16] = int'(in1);
            end
            if (stop) begin
              m_st[i] = ST_DONE; flush(i);
            end else if (m && m_sof[i]) begin
              m_st[i] = ST_HALT; flush(i);
            end
          end
          default: ;
        endcase
      end
    end
    cyc++;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string n, input int i, input int st, input int cc,
                          input int ec, input int mis, input int fl, input int fd,
                          input int fc);
    chk({n, "_state"}, st, m_st[i]);
    chk({n, "_check_count"}, cc, m_cc[i]);
    chk({n, "_err_count"}, ec, m_ec[i]);
    chk({n, "_mismatch"}, mis, m_mis[i]);
    chk({n, "_fail"}, fl, m_fail[i]);
    chk({n, "_fail_data"}, fd, CAP ? m_fd[i] : 0);
    chk({n, "_fail_cycle"}, fc, CAP ? m_fc[i] : 0);
  endtask

  task automatic check_all();
    chk_inst("main", 0, int'(a_state), int'(a_cc), int'(a_ec), int'(a_mis),
             int'(a_fail), int'(a_fd), int'(a_fc));
    chk_inst("halt", 1, int'(b_state), int'(b_cc), int'(b_ec), int'(b_mis),
             int'(b_fail), int'(b_fd), int'(b_fc));
    chk_inst("sat", 2, int'(c_state), int'(c_cc), int'(c_ec), int'(c_mis),
             int'(c_fail), int'(c_fd), int'(c_fc));
  endtask

  task automatic step(input bit r, input bit s, input bit p, input bit v,
                      input logic [W-1:0] d, input bit o);
    rst = r; start = s; stop = p; in_valid = v; in1 = d; dut_out = o;
    model_tick();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit prev_exp;
    bit r, s, p, v, o;
    logic [W-1:0] d;

    for (int i = 0; i < 3; i++) flush(i);

    // 1. reset for two cycles
    step(1, 0, 0, 0, 4'h0, 0);
    step(1, 0, 0, 0, 4'h0, 0);
    chk("t1_state", int'(a_state), 0);
    chk("t1_check_count", int'(a_cc), 0);
    chk("t1_err_count", int'(a_ec), 0);
    chk("t1_fail", int'(a_fail), 0);
    chk("t1_mismatch", int'(a_mis), 0);

    // 2. start, matching sample
    step(0, 1, 0, 0, 4'h0, 0);
    chk("t2_state_run", int'(a_state), 1);
    step(0, 0, 0, 1, 4'hF, 0);
    step(0, 0, 0, 0, 4'h0, 1);
    chk("t2_check_count", int'(a_cc), 1);
    chk("t2_err_count", int'(a_ec), 0);
    chk("t2_fail", int'(a_fail), 0);

    // 3. mismatching sample
    step(0, 0, 0, 1, 4'h3, 0);
    step(0, 0, 0, 0, 4'h0, 1);
    chk("t3_mismatch", int'(a_mis), 1);
    chk("t3_err_count", int'(a_ec), 1);
    chk("t3_fail", int'(a_fail), 1);
    chk("t3_fail_data", int'(a_fd), CAP ? 3 : 0);
    chk("t3_fail_cycle", int'(a_fc), CAP ? 1 : 0);
    chk("t3_halt_state", int'(b_state), 2);

    // 4. five matching samples, the halted instance stays frozen
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 4'hF, (k == 0) ? 1'b0 : 1'b1);
    step(0, 0, 0, 0, 4'h0, 1);
    chk("t4_halt_state", int'(b_state), 2);
    chk("t4_halt_check_count", int'(b_cc), 2);
    chk("t4_halt_err_count", int'(b_ec), 1);
    chk("t3_mismatch_pulse_done", int'(a_mis), 0);

    // 5. restart and saturate the narrow counter
    step(0, 0, 1, 0, 4'h0, 0);
    step(0, 1, 0, 0, 4'h0, 0);
    for (int k = 0; k < 20; k++) step(0, 0, 0, 1, 4'hF, (k == 0) ? 1'b0 : 1'b1);
    step(0, 0, 0, 0, 4'h0, 1);
    chk("t5_sat_check_count", int'(c_cc), 15);
    chk("t5_sat_err_count", int'(c_ec), 0);
    chk("t5_main_check_count", int'(a_cc), 20);

    // 6. stop with a sample in flight, then restart
    step(0, 0, 1, 1, 4'hF, 1);
    chk("t6_state_done", int'(a_state), 3);
    step(0, 0, 0, 0, 4'h0, 1);
    chk("t6_inflight_dropped", int'(a_cc), 20);
    step(0, 1, 0, 0, 4'h0, 0);
    chk("t6_restart_state", int'(a_state), 1);
    chk("t6_restart_count", int'(a_cc), 0);
    chk("t6_restart_fail", int'(a_fail), 0);

    // 7. randomized traffic, including mid-run resets
    step(1, 0, 0, 0, 4'h0, 0);
    prev_exp = 1'b0;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 99) == 0);
      s = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 15) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 1) == 1) ? 4'hF : W'($urandom_range(0, ALL));
      o = prev_exp ^ ($urandom_range(0, 5) == 0);
      step(r, s, p, v, d, o);
      prev_exp = v && (d == 4'hF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
